fifo_stream_reader: RTL and testbench

//  Read-side master for the single-clock-DPRAM FIFO (wrclk = rdclk = clk). Pops words with

---
 rtl/fifo_stream_reader_pkg.sv | 24 ++
 rtl/fifo_stream_reader_if.sv | 35 +++
 rtl/fifo_stream_reader_skid.sv | 83 ++++++++
 rtl/fifo_stream_reader.sv | 69 ++++++
 tb/tb_fifo_stream_reader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO read-side stream master and its neighbours
// (FIFO core, writer-side blocks).
//   FIFO_WIDTH/FIFO_DEPTH/FIFO_PTR : default FIFO geometry
//   SKID_DEPTH                     : entries in the reader's skid buffer
//   occ_e                          : skid buffer occupancy (also the reader FSM state)
//   occ_count()                    : occupancy as an unsigned word count
package fifo_stream_reader_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_PTR   = 4;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e occ);
    return occ;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bus bundle between the stream reader, the FIFO read port and the downstream sink.
//   fifo_rdempty : FIFO empty flag (combinational from the FIFO pointers)
//   fifo_rden    : FIFO read request
//   fifo_dataout : FIFO read data, valid the cycle after an accepted fifo_rden
//   m_valid      : stream word valid
//   m_data       : stream word
//   m_ready      : downstream accept
// Handshake: a word moves on every clock edge where m_valid & m_ready are both high.
// Once m_valid is raised it stays high and m_data stays constant until that edge;
// m_ready may be driven freely and may depend on m_valid.
// Modports: master = the reader, slave = its environment (FIFO + sink).
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);

  logic             fifo_rdempty;
  logic             fifo_rden;
  logic [WIDTH-1:0] fifo_dataout;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_rdempty, fifo_dataout, m_ready,
    output fifo_rden, m_valid, m_data
  );

  modport slave (
    output fifo_rdempty, fifo_dataout, m_ready,
    input  fifo_rden, m_valid, m_data
  );

endinterface

// File: rtl/fifo_stream_reader_skid.sv
// skid_buf2: two-entry register buffer holding words returned by the FIFO.
// The head entry drives the stream output directly, so m_valid/m_data come
// straight from flops.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : capture din_i at the tail
//   pop_i      : head word accepted downstream
//   flush_i    : empty the buffer on the next edge (overrides push/pop)
//   din_i      : word to capture
//   occ_o      : current occupancy (FSM state)
//   valid_o    : buffer not empty
//   head_o     : oldest buffered word
module skid_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output occ_e             occ_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  occ_e             occ_q;
  logic [WIDTH-1:0] e0_q;  // head
  logic [WIDTH-1:0] e1_q;  // second word, only meaningful in OCC_TWO

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= OCC_EMPTY;
      e0_q  <= '0;
      e1_q  <= '0;
    end else if (flush_i) begin
      occ_q <= OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            e0_q  <= din_i;
            occ_q <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push_i, pop_i})
            2'b10: begin
              e1_q  <= din_i;
              occ_q <= OCC_TWO;
            end
            2'b01: occ_q <= OCC_EMPTY;
            2'b11: e0_q  <= din_i;  // head leaves, new word becomes head
            default: ;
          endcase
        end
        OCC_TWO: begin
          // A push here is illegal; the push&pop case still keeps order intact.
          if (pop_i) begin
            e0_q <= e1_q;
            if (push_i) e1_q  <= din_i;
            else        occ_q <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

  // The reader's credit logic must never let a word arrive into a full buffer.
  always @(posedge clk) begin
    if (rst_n && !flush_i) begin
      assert (!(push_i && occ_q == OCC_TWO))
        else $error("skid_buf2: push while buffer holds two words");
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != OCC_EMPTY);
  assign head_o  = e0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for a single-clock DPRAM FIFO. Pops words
// with fifo_rden and presents them as a valid/ready stream at one word per cycle.
// Because fifo_dataout returns one cycle after fifo_rden, reads are issued against
// credits in a two-entry skid buffer so no returning word is ever dropped.
//   clk      : single clock shared with the FIFO
//   reset_   : asynchronous active-low reset
//   flush    : drop buffered and in-flight words, no reads while high
//   bus      : FIFO read port + output stream (master modport)
//   rd_count : words delivered downstream, wraps modulo 2**CNT_W
//   occ_dbg  : skid occupancy (reader FSM state)
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     rd_count,
  output occ_e                 occ_dbg
);

  occ_e             occ;
  logic             pop;
  logic             push;
  logic             rden;
  logic             inflight_q;  // a word is returning from the FIFO this cycle
  logic [2:0]       used;
  logic [CNT_W-1:0] rd_count_q;

  assign pop  = bus.m_valid & bus.m_ready;
  assign push = inflight_q & ~flush;

  // Slots already spoken for: buffered words plus the one on its way back.
  // A slot freed by this cycle's pop can be reused, so compare against 2 + pop
  // rather than subtracting (pop implies occ >= 1, but this avoids any underflow).
  assign used = {1'b0, occ_count(occ)} + {2'b00, inflight_q};
  assign rden = reset_ & ~flush & ~bus.fifo_rdempty & (used < (3'd2 + {2'b00, pop}));

  assign bus.fifo_rden = rden;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= rden;
      if (pop) rd_count_q <= rd_count_q + 1'b1;
    end
  end

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (reset_),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (bus.fifo_dataout),
    .occ_o   (occ),
    .valid_o (bus.m_valid),
    .head_o  (bus.m_data)
  );

  assign rd_count = rd_count_q;
  assign occ_dbg  = occ;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_;
  logic          flush;
  logic [CW-1:0] rd_count;
  occ_e          occ_dbg;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(W)) bus ();

  fifo_stream_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .flush    (flush),
    .bus      (bus),
    .rd_count (rd_count),
    .occ_dbg  (occ_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            wr_cnt = 0;
  logic [CW-1:0] del_cnt = '0;
  logic          mon_en = 1'b0;
  logic          hold_prev = 1'b0;
  logic [W-1:0]  data_prev = '0;

  // ---------------- FIFO model (DEPTH=16, registered dataout) ----------------
  logic [W-1:0] mem [16];
  logic [3:0]   wradr, rdadr;
  logic         wren, fifo_clr, fifo_full;
  logic [W-1:0] wrdata;

  assign bus.fifo_rdempty = (wradr == rdadr);
  assign fifo_full        = (4'(wradr + 4'd1) == rdadr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wradr <= '0;
      rdadr <= '0;
    end else begin
      if (wren && !fifo_full) begin
        mem[wradr] <= wrdata;
        wradr      <= wradr + 4'd1;
        exp_q.push_back(wrdata);
        wr_cnt++;
      end
      if (bus.fifo_rden) begin
        bus.fifo_dataout <= mem[rdadr];
        rdadr            <= rdadr + 4'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // ---------------- stream monitor ----------------
  always @(negedge clk) begin
    if (mon_en && reset_ === 1'b1) begin
      if (bus.fifo_rden) chk("rden_while_empty", 32'(bus.fifo_rdempty), 0);
      chk("occ_range", 32'(occ_dbg <= OCC_TWO), 1);
      if (hold_prev) begin
        chk("hold_valid", 32'(bus.m_valid), 1);
        chk("hold_data", 32'(bus.m_data), 32'(data_prev));
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("sb_has_word", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        del_cnt = del_cnt + 16'd1;
      end
      hold_prev = bus.m_valid & ~bus.m_ready & ~flush;
      data_prev = bus.m_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [W-1:0] base, input int n, input int step);
    for (int i = 0; i < n; i++) begin
      wren   = 1'b1;
      wrdata = 8'(int'(base) + i * step);
      tick();
    end
    wren = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.m_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_count"}, 32'(rd_count), 32'(del_cnt));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(bus.m_valid), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rden_cnt;
    int wr_base;
    int n;

    reset_ = 1'b0; flush = 1'b0; wren = 1'b0; wrdata = '0; fifo_clr = 1'b1;
    bus.m_ready = 1'b0;
    repeat (2) tick();

    // reset state
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_rden", 32'(bus.fifo_rden), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_occ", 32'(occ_dbg), 32'(OCC_EMPTY));
    tick();
    fifo_clr = 1'b0; reset_ = 1'b1; flush = 1'b1; mon_en = 1'b1;
    tick();

    // 1: three words, latency and back-to-back delivery
    write_words(8'h11, 3, 'h11);
    flush = 1'b0; bus.m_ready = 1'b1;
    @(negedge clk);
    chk("t1_rden_first", 32'(bus.fifo_rden), 1);
    chk("t1_valid_c0", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("t1_valid_c1", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("t1_valid_c2", 32'(bus.m_valid), 1);
    chk("t1_data_0", 32'(bus.m_data), 'h11);
    @(negedge clk);
    chk("t1_data_1", 32'(bus.m_data), 'h22);
    @(negedge clk);
    chk("t1_data_2", 32'(bus.m_data), 'h33);
    @(negedge clk);
    chk("t1_valid_end", 32'(bus.m_valid), 0);
    chk("t1_rd_count", 32'(rd_count), 3);
    tick();

    // 2: fifteen words under 10 cycles of backpressure, then full-rate drain
    flush = 1'b1;
    write_words(8'h00, 15, 1);
    flush = 1'b0; bus.m_ready = 1'b0;
    rden_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.fifo_rden) rden_cnt++;
    end
    chk("t2_rden_pulses", rden_cnt, 2);
    chk("t2_valid_held", 32'(bus.m_valid), 1);
    chk("t2_data_held", 32'(bus.m_data), 'h00);
    chk("t2_occ_two", 32'(occ_dbg), 32'(OCC_TWO));
    tick();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t2_burst_valid", 32'(bus.m_valid), 1);
      chk("t2_burst_data", 32'(bus.m_data), i);
    end
    @(negedge clk);
    chk("t2_valid_end", 32'(bus.m_valid), 0);
    chk("t2_rd_count", 32'(rd_count), 18);
    tick();

    // 3: random backpressure with concurrent random writes
    wr_base = wr_cnt;
    n = 0;
    while ((wr_cnt - wr_base) < 1000 && n < 20000) begin
      wren        = 1'($urandom_range(0, 1));
      wrdata      = 8'($urandom_range(0, 255));
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    wren = 1'b0;
    chk("t3_words_written", 32'((wr_cnt - wr_base) >= 1000), 1);
    drain("t3");

    // 4: flush discards the buffered head and the word returning from the FIFO
    flush = 1'b1;
    write_words(8'hA0, 6, 1);
    flush = 1'b0; bus.m_ready = 1'b0;
    @(negedge clk);
    chk("t4_rden_c0", 32'(bus.fifo_rden), 1);
    @(negedge clk);
    chk("t4_rden_c1", 32'(bus.fifo_rden), 1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("t4_occ_before", 32'(occ_dbg), 32'(OCC_ONE));
    chk("t4_rden_in_flush", 32'(bus.fifo_rden), 0);
    chk("t4_head_before", 32'(bus.m_data), 'hA0);
    tick();
    flush = 1'b0;
    void'(exp_q.pop_front());  // 0xA0 buffered
    void'(exp_q.pop_front());  // 0xA1 in flight
    @(negedge clk);
    chk("t4_valid_after", 32'(bus.m_valid), 0);
    chk("t4_rden_resume", 32'(bus.fifo_rden), 1);
    n = 0;
    while (occ_dbg != OCC_TWO && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_two", 32'(occ_dbg), 32'(OCC_TWO));
    chk("t4_next_head", 32'(bus.m_data), 'hA2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp_q.pop_front());  // 0xA2
    void'(exp_q.pop_front());  // 0xA3
    @(negedge clk);
    chk("t4_valid_after_two", 32'(bus.m_valid), 0);
    tick();
    bus.m_ready = 1'b1;
    wait_valid("t4");
    chk("t4_resume_word", 32'(bus.m_data), 'hA4);
    tick();
    drain("t4");

    // 5: asynchronous reset in the middle of a stream
    flush = 1'b1;
    write_words(8'hB0, 8, 1);
    flush = 1'b0; bus.m_ready = 1'b1;
    tick(); tick(); tick();
    #2;
    reset_ = 1'b0;
    #1;
    chk("t5_valid_async", 32'(bus.m_valid), 0);
    chk("t5_rden_async", 32'(bus.fifo_rden), 0);
    chk("t5_count_async", 32'(rd_count), 0);
    chk("t5_occ_async", 32'(occ_dbg), 32'(OCC_EMPTY));
    exp_q.delete();
    for (int i = 3; i < 8; i++) exp_q.push_back(8'(8'hB0 + i));
    del_cnt = '0;
    tick();
    reset_ = 1'b1;
    wait_valid("t5");
    chk("t5_first_after_reset", 32'(bus.m_data), 'hB3);
    tick();
    drain("t5");
    chk("t5_rd_count", 32'(rd_count), 5);

    // 6: counter wrap
    force dut.rd_count_q = 16'hFFFE;
    #1;
    release dut.rd_count_q;
    del_cnt = 16'hFFFE;
    tick();
    write_words(8'hC0, 3, 1);
    drain("t6");
    chk("t6_rd_count_wrap", 32'(rd_count), 'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
